// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready request, LATENCY wait states, one-cycle response.
// Define MEM_MISALIGN_TRAP_EN to turn misaligned accesses into error responses.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e state, stateNext;

  logic [63:0] mem [DEPTH] = '{default: '0};

  logic             capWrite;
  logic [2:0]       capF3;
  logic [IDX_W+2:0] capAddr;
  logic [63:0]      capWdata;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      rdataQ;
  logic             errQ;

  logic [1:0]       size;
  logic [2:0]       lane;
  logic [2:0]       effLane;
  logic [IDX_W-1:0] idx;
  logic             misalign;
  logic             illegal;
  logic             accErr;
  logic [7:0]       be;
  logic [7:0]       beShift;
  logic [63:0]      word;
  logic [63:0]      shifted;
  logic [63:0]      loadVal;
  logic [63:0]      wShift;
  logic [63:0]      merged;
  logic             commit;

  logic unusedAddrBits;
  assign unusedAddrBits = ^req_addr[ADDR_W-1:IDX_W+3];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (req_valid) stateNext = WAIT;
      WAIT:    if (cnt == '0) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdataQ;
  assign resp_err   = errQ;

  // Lane is always naturally aligned; the trap build blocks misaligned accesses via accErr.
  always_comb begin
    size     = capF3[1:0];
    lane     = capAddr[2:0];
    idx      = capAddr[IDX_W+2:3];
    misalign = 1'b0;
    effLane  = lane;
    be       = 8'h01;
    case (size)
      2'd0: be = 8'h01;
      2'd1: begin
        be       = 8'h03;
        misalign = lane[0];
        effLane  = {lane[2:1], 1'b0};
      end
      2'd2: begin
        be       = 8'h0F;
        misalign = |lane[1:0];
        effLane  = {lane[2], 2'b00};
      end
      default: begin
        be       = 8'hFF;
        misalign = |lane;
        effLane  = 3'b000;
      end
    endcase
    illegal = capWrite ? capF3[2] : (capF3 == 3'b111);
`ifdef MEM_MISALIGN_TRAP_EN
    accErr = illegal | misalign;
`else
    accErr = illegal;
`endif
    word    = mem[idx];
    shifted = word >> {effLane, 3'b000};
    unique case (capF3)
      3'b000:  loadVal = {{56{shifted[7]}}, shifted[7:0]};
      3'b001:  loadVal = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  loadVal = {{32{shifted[31]}}, shifted[31:0]};
      3'b011:  loadVal = shifted;
      3'b100:  loadVal = {56'b0, shifted[7:0]};
      3'b101:  loadVal = {48'b0, shifted[15:0]};
      3'b110:  loadVal = {32'b0, shifted[31:0]};
      default: loadVal = '0;
    endcase
    beShift = be << effLane;
    wShift  = capWdata << {effLane, 3'b000};
    for (int b = 0; b < 8; b++) begin
      merged[8*b +: 8] = beShift[b] ? wShift[8*b +: 8] : word[8*b +: 8];
    end
    commit = (state == WAIT) && (cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      capWrite <= req_write;
      capF3    <= req_funct3;
      capAddr  <= req_addr[IDX_W+2:0];
      capWdata <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      rdataQ <= '0;
      errQ   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (req_valid) cnt <= CNT_W'(LATENCY - 1);
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            rdataQ <= (capWrite || accErr) ? '0 : loadVal;
            errQ   <= accErr;
          end
        end
        RESP: begin
          rdataQ <= '0;
          errQ   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && commit && capWrite && !accErr) mem[idx] <= merged;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder with LATENCY=2.
// Expectations follow MEM_MISALIGN_TRAP_EN when it is defined.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  typedef struct {
    logic [63:0] d;
    logic        e;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   passCnt = 0;
  int   totalCnt = 0;
  int   failCnt = 0;

  data_mem_responder #(
    .DEPTH(256),
    .ADDR_W(32),
    .LATENCY(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_funct3(req_funct3),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 64'(resp_valid), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_rdata"}, resp_rdata, e.d);
        check({e.tag, "_err"}, 64'(resp_err), 64'(e.e));
      end
    end
  end

  task automatic drive(input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [63:0] wd);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  task automatic window(input string tag);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check({tag, "_rv"}, 64'(resp_valid), 64'(k == 3));
      check({tag, "_rdy"}, 64'(req_ready), 64'(k == 4));
      check({tag, "_busy"}, 64'(busy), 64'(k != 4));
      if (k != 3) begin
        check({tag, "_idle_rdata"}, resp_rdata, 64'(0));
        check({tag, "_idle_err"}, 64'(resp_err), 64'(0));
      end
    end
  endtask

  task automatic doReq(input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [63:0] wd,
                       input logic [63:0] expD, input logic expE,
                       input string tag);
    int n;
    @(negedge clk);
    drive(w, f3, a, wd);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check({tag, "_accept_timeout"}, 64'(req_ready), 64'(1));
      req_valid = 1'b0;
      return;
    end
    sb.push_back('{expD, expE, tag});
    @(posedge clk);
    #1 req_valid = 1'b0;
    window(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] expLw11;
    logic        expLw11E;
    logic [63:0] expSw13;
    logic        expSw13E;
    logic [63:0] expWord;
`ifdef MEM_MISALIGN_TRAP_EN
    expLw11  = 64'h0;
    expLw11E = 1'b1;
    expSw13  = 64'h0;
    expSw13E = 1'b1;
    expWord  = 64'h11223344BEEF7788;
`else
    expLw11  = 64'hFFFFFFFFBEEF7788;
    expLw11E = 1'b0;
    expSw13  = 64'h0;
    expSw13E = 1'b0;
    expWord  = 64'h11223344DEADBEEF;
`endif
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rv", 64'(resp_valid), 64'(0));
    check("rst_rdata", resp_rdata, 64'(0));
    check("rst_err", 64'(resp_err), 64'(0));
    reset = 1'b0;

    doReq(1, 3'b011, 32'h10, 64'h1122334455667788, 64'h0, 0, "sd10");
    doReq(0, 3'b011, 32'h10, 64'h0, 64'h1122334455667788, 0, "ld10");
    doReq(0, 3'b000, 32'h10, 64'h0, 64'hFFFFFFFFFFFFFF88, 0, "lb10");
    doReq(0, 3'b100, 32'h10, 64'h0, 64'h0000000000000088, 0, "lbu10");
    doReq(0, 3'b000, 32'h17, 64'h0, 64'h0000000000000011, 0, "lb17");
    doReq(1, 3'b001, 32'h12, 64'hFFFFFFFFFFFFBEEF, 64'h0, 0, "sh12");
    doReq(0, 3'b011, 32'h10, 64'h0, 64'h11223344BEEF7788, 0, "ld10_sh");
    doReq(0, 3'b001, 32'h12, 64'h0, 64'hFFFFFFFFFFFFBEEF, 0, "lh12");
    doReq(0, 3'b101, 32'h12, 64'h0, 64'h000000000000BEEF, 0, "lhu12");
    doReq(0, 3'b010, 32'h11, 64'h0, expLw11, expLw11E, "lw11");
    doReq(0, 3'b011, 32'h810, 64'h0, 64'h11223344BEEF7788, 0, "ld_wrap");
    doReq(1, 3'b010, 32'h13, 64'hDEADBEEF, expSw13, expSw13E, "sw13");
    doReq(0, 3'b011, 32'h10, 64'h0, expWord, 0, "ld10_sw");
    doReq(1, 3'b100, 32'h10, 64'h0, 64'h0, 1, "st_f4");
    doReq(0, 3'b011, 32'h10, 64'h0, expWord, 0, "ld10_f4");
    doReq(0, 3'b111, 32'h10, 64'h0, 64'h0, 1, "ld_f7");

    @(negedge clk);
    drive(1, 3'b011, 32'h20, 64'hAA);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_busy", 64'(busy), 64'(0));
    check("rstmid_ready", 64'(req_ready), 64'(1));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rstmid_rv", 64'(resp_valid), 64'(0));
    end
    doReq(0, 3'b011, 32'h20, 64'h0, 64'h0, 0, "ld20");

    @(negedge clk);
    drive(0, 3'b011, 32'h10, 64'h0);
    sb.push_back('{expWord, 1'b0, "holdA"});
    @(posedge clk);
    #1 drive(0, 3'b100, 32'h17, 64'h0);
    sb.push_back('{64'h11, 1'b0, "holdB"});
    window("holdA");
    @(posedge clk);
    #1 req_valid = 1'b0;
    window("holdB");

    repeat (3) @(negedge clk);
    check("sb_drain", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the data-memory access interface driven by the multicycle control unit (LD/SD and the byte/half/word variants).
- Accepts one request at a time through a valid/ready handshake and models LATENCY wait states.
- Performs size-aware reads with sign or zero extension, and byte-enable-merged writes, on an internal 64-bit-wide RAM.
- Returns a single-cycle response pulse carrying read data and an error flag.

Parameters:
- DEPTH, 256, number of 64-bit words in the RAM (power of 2).
- ADDR_W, 32, byte address width.
- LATENCY, 2, wait-state cycles between acceptance and the memory access (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present; held until accepted.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 size/sign code.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  64  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  64  extended load data.
- resp_err  out  1  request rejected, no memory effect.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, wait counter 0.
- RAM contents are not cleared by reset; they are zero-initialised at time 0.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, capture write/funct3/addr/wdata, load counter=LATENCY-1, go WAIT.
- WAIT:
  - req_ready=0.
  - Decrement counter.
  - When counter==0, perform the access at that clock edge (write commit or read-data register) and go RESP.
- RESP:
  - resp_valid=1, resp_rdata and resp_err driven for exactly this cycle; next state IDLE.
- Latency: accept in cycle 0 -> resp_valid in cycle LATENCY+1 -> req_ready=1 again in cycle LATENCY+2.
- Requests presented while busy are ignored, not queued.
- resp_rdata and resp_err are 0 outside RESP. resp_rdata is 0 on every store response.
- Word index = req_addr[3 +: log2(DEPTH)]. Upper address bits are ignored, so addresses wrap modulo DEPTH*8. Lane = req_addr[2:0].
- Loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
  - Data = word >> (8*lane), truncated to the access size.
  - Sign-extended for 000/001/010, zero-extended for 100/101/110.
  - 111 -> resp_err=1, rdata=0.
- Stores: 000 SB, 001 SH, 010 SW, 011 SD.
  - Write only the addressed bytes (byte-enable mask shifted by lane); the other bytes of the word are preserved.
  - funct3 >= 100 -> resp_err=1, no write.
- Misalignment means lane is not a multiple of the access size. Handling depends on the macro below.
- Reset mid-operation: IDLE on the next cycle, no resp_valid. A store whose commit edge has not occurred is discarded.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access causes no RAM read or write.
  - The response gives resp_err=1, rdata=0, with the same LATENCY+1 timing.
- Undefined:
  - Lane bits below the access size are forced to 0, giving natural alignment; the access proceeds with resp_err=0.
  - Misalignment never raises an error.

Test Plan:
- LATENCY=2:
  - SD 0x1122334455667788 @0x10, then LD @0x10 -> rdata 0x1122334455667788.
  - resp_valid exactly 3 cycles after each accept, high for 1 cycle.
  - req_ready low for 3 cycles after each accept.
- Byte loads after the above:
  - LB @0x10 -> 0xFFFFFFFFFFFFFF88.
  - LBU @0x10 -> 0x0000000000000088.
  - LB @0x17 -> 0x0000000000000011.
- SH 0xBEEF @0x12 (wdata 0xFFFF...BEEF):
  - LD @0x10 -> 0x11223344BEEF7788.
  - LH @0x12 -> 0xFFFFFFFFFFFFBEEF.
  - LHU @0x12 -> 0x000000000000BEEF.
- LW @0x11 (misaligned):
  - Without macro -> 0xFFFFFFFFBEEF7788, err=0.
  - With MEM_MISALIGN_TRAP_EN -> rdata=0, err=1.
  - SW @0x13 with macro -> err=1 and word @0x10 unchanged.
- Reset pulse during WAIT of SD 0xAA @0x20 -> no resp_valid; subsequent LD @0x20 -> 0, err=0.
- Load funct3=111 -> err=1, rdata=0.
- Store funct3=100 -> err=1, no RAM change.
- Second req_valid held while busy -> accepted only in the cycle after RESP.
